reg_writeback: RTL

- Per-thread writeback unit. It is the writer side of the thread register file's write port.
- Samples the decoded write request in the UPDATE core state and selects the result source: ALU, LSU or immediate.
- For loads, waits on an LSU valid/ready handshake before issuing the write.
- Drives a registered single-cycle write strobe into the register file.
- Exposes a pending-write scoreboard so operand fetch can detect read-after-write hazards.

---
 rtl/reg_writeback.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/reg_writeback.sv
// reg_writeback: per-thread writeback unit driving the register-file write port.
// Captures a decoded write in UPDATE, selects ALU/LSU/immediate data, waits on
// the LSU handshake for loads, and issues a one-cycle registered write strobe.
// A pending-write scoreboard flags read-after-write hazards to operand fetch.
module reg_writeback #(
    parameter int DATA_BITS     = 8,
    parameter int WRITABLE_REGS = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           core_state,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [3:0]           decoded_rd_address,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic [DATA_BITS-1:0] decoded_immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic                 lsu_valid,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_ready,
    output logic                 wb_enable,
    output logic [3:0]           wb_address,
    output logic [DATA_BITS-1:0] wb_data,
    output logic                 busy,
    output logic                 hazard,
    output logic [7:0]           reject_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_LSU = 2'b01,
        WRITE    = 2'b10
    } state_t;

    localparam logic [2:0] UPDATE   = 3'b110;
    localparam logic [1:0] MUX_ALU  = 2'b00;
    localparam logic [1:0] MUX_MEM  = 2'b01;
    localparam logic [1:0] MUX_IMM  = 2'b10;
    // One extra bit so WRITABLE_REGS == 16 still compares correctly.
    localparam logic [4:0] RD_LIMIT = 5'(WRITABLE_REGS);

    state_t               state_q, state_d;
    logic [3:0]           rd_q, rd_d;
    logic                 pending_q, pending_d;
    logic                 wb_enable_q, wb_enable_d;
    logic [3:0]           wb_address_q, wb_address_d;
    logic [DATA_BITS-1:0] wb_data_q, wb_data_d;
    logic [7:0]           reject_count_q, reject_count_d;

    logic req;
    logic req_bad;

    assign req     = (core_state == UPDATE) && decoded_reg_write_enable;
    assign req_bad = ({1'b0, decoded_rd_address} >= RD_LIMIT) ||
                     (decoded_reg_input_mux == 2'b11);

    // Next-state and write-port update; the write port registers are loaded
    // on the edge entering WRITE so the strobe is high exactly in that cycle.
    always_comb begin
        state_d        = state_q;
        rd_d           = rd_q;
        pending_d      = pending_q;
        wb_enable_d    = 1'b0;
        wb_address_d   = wb_address_q;
        wb_data_d      = wb_data_q;
        reject_count_d = reject_count_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (req_bad) begin
                        if (reject_count_q != 8'hFF)
                            reject_count_d = reject_count_q + 8'd1;
                    end else begin
                        rd_d = decoded_rd_address;
                        case (decoded_reg_input_mux)
                            MUX_ALU: begin
                                wb_address_d = decoded_rd_address;
                                wb_data_d    = alu_out;
                                wb_enable_d  = 1'b1;
                                state_d      = WRITE;
                            end
                            MUX_IMM: begin
                                wb_address_d = decoded_rd_address;
                                wb_data_d    = decoded_immediate;
                                wb_enable_d  = 1'b1;
                                state_d      = WRITE;
                            end
                            MUX_MEM: begin
                                pending_d = 1'b1;
                                state_d   = WAIT_LSU;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WAIT_LSU: begin
                // lsu_ready is high here, so lsu_valid alone completes the transfer
                if (lsu_valid) begin
                    wb_address_d = rd_q;
                    wb_data_d    = lsu_out;
                    wb_enable_d  = 1'b1;
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                pending_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                pending_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            rd_q           <= '0;
            pending_q      <= 1'b0;
            wb_enable_q    <= 1'b0;
            wb_address_q   <= '0;
            wb_data_q      <= '0;
            reject_count_q <= '0;
        end else begin
            state_q        <= state_d;
            rd_q           <= rd_d;
            pending_q      <= pending_d;
            wb_enable_q    <= wb_enable_d;
            wb_address_q   <= wb_address_d;
            wb_data_q      <= wb_data_d;
            reject_count_q <= reject_count_d;
        end
    end

    assign lsu_ready    = (state_q == WAIT_LSU);
    assign busy         = (state_q != IDLE);
    assign wb_enable    = wb_enable_q;
    assign wb_address   = wb_address_q;
    assign wb_data      = wb_data_q;
    assign reject_count = reject_count_q;
    assign hazard       = pending_q &&
                          ((rd_q == decoded_rs_address) || (rd_q == decoded_rt_address));

endmodule
